// File: rtl/niosii_ram_arb_pkg.sv
// Shared definitions for the two-port on-chip RAM arbiter.
package niosii_ram_arb_pkg;

    localparam int DEF_ADDR_W    = 13;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_BE_W      = 4;
    localparam int DEF_RAM_DEPTH = 6400;

    // Port indices into the request/grant vectors
    localparam int P0 = 0;
    localparam int P1 = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } arb_state_t;

    // Unsigned check of a word address against the implemented depth
    function automatic logic addr_oor(input logic [31:0] addr, input logic [31:0] depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/niosii_rr_arb2.sv
// Two-way round-robin grant. On a tie the port that was not granted most
// recently wins; the last-grant register resets pointing at s1 so s0 wins
// the first tie.
module niosii_rr_arb2
    import niosii_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_s1;

    // Grant: single requester wins outright, ties go to the other port
    always_comb begin
        gnt = 2'b00;
        if (req[P0] && req[P1]) begin
            if (last_s1) gnt[P0] = 1'b1;
            else         gnt[P1] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    // Remember which port took the most recent grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_s1 <= 1'b1;
        else if (advance && (|gnt))
            last_s1 <= gnt[P1];
    end

endmodule

// File: rtl/niosii_ram_arbiter.sv
// Avalon-MM arbiter sharing one single-port on-chip RAM between the Nios II
// data master (s0) and a second master (s1). One access per clock,
// round-robin, optional zero-fill after reset, sticky out-of-range flag.
module niosii_ram_arbiter
    import niosii_ram_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int BE_W           = DEF_BE_W,
    parameter int RAM_DEPTH      = DEF_RAM_DEPTH,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              clear_done,
    output logic              oor_err
);

    localparam int               CNT_W       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(RAM_DEPTH - 1);
    localparam arb_state_t       RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  clr_cnt;
    logic              arb_en;
    logic [1:0]        req, gnt;
    logic              sel_s1, sel_wr, sel_rd, sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wd;
    logic              vld_p1, owner_p1, oor_p1;
    logic [DATA_W-1:0] rdata;

    // Requests are only seen while arbitrating; reset forces everything idle
    assign arb_en = (state == ST_ARB) && !reset;
    assign req    = {s1_read | s1_write, s0_read | s0_write} & {2{arb_en}};

    niosii_rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (arb_en),
        .gnt     (gnt)
    );

    // Steer the granted port onto one set of signals; write beats read
    always_comb begin
        sel_s1   = gnt[P1];
        sel_addr = sel_s1 ? s1_address    : s0_address;
        sel_be   = sel_s1 ? s1_byteenable : s0_byteenable;
        sel_wd   = sel_s1 ? s1_writedata  : s0_writedata;
        sel_wr   = sel_s1 ? s1_write      : s0_write;
        sel_rd   = (sel_s1 ? s1_read : s0_read) & ~sel_wr;
        sel_oor  = addr_oor(32'(sel_addr), 32'(RAM_DEPTH));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_nxt;
    end

    // Next state: leave the clear sweep after the last word is written
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_cnt == CNT_LAST)
            state_nxt = ST_ARB;
    end

    // Clear sweep address counter, restarts at 0 on every reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  clr_cnt <= '0;
        else if (state == ST_CLEAR) clr_cnt <= clr_cnt + CNT_W'(1);
    end

    // Outputs: RAM port driven by the clear sweep or by the granted master
    always_comb begin
        s0_waitrequest = 1'b1;
        s1_waitrequest = 1'b1;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        if (state == ST_CLEAR && !reset) begin
            ram_address    = ADDR_W'(clr_cnt);
            ram_byteenable = '1;
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
        end else if (|gnt) begin
            s0_waitrequest = ~gnt[P0];
            s1_waitrequest = ~gnt[P1];
            ram_address    = sel_addr;
            ram_byteenable = sel_be;
            ram_writedata  = sel_wd;
            // Out-of-range accesses are accepted but never reach the RAM
            ram_chipselect = ~sel_oor;
            ram_write      = sel_wr & ~sel_oor;
        end
    end

    assign clear_done = (state == ST_ARB);
    assign ram_clken  = 1'b1;

    // Read response stage: owner and range status of the read issued this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            owner_p1 <= 1'b0;
            oor_p1   <= 1'b0;
        end else begin
            vld_p1   <= (|gnt) & sel_rd;
            owner_p1 <= sel_s1;
            oor_p1   <= sel_oor;
        end
    end

    assign rdata            = oor_p1 ? '0 : ram_readdata;
    assign s0_readdatavalid = vld_p1 & ~owner_p1;
    assign s1_readdatavalid = vld_p1 & owner_p1;
    assign s0_readdata      = s0_readdatavalid ? rdata : '0;
    assign s1_readdata      = s1_readdatavalid ? rdata : '0;

    // Sticky out-of-range flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                oor_err <= 1'b0;
        else if ((|gnt) && sel_oor) oor_err <= 1'b1;
    end

endmodule

// File: tb/tb_niosii_ram_arbiter.sv
// Bench for niosii_ram_arbiter: clear sweep, table of directed cycles,
// randomized traffic against a behavioural model, reset/out-of-range corners.
module tb_niosii_ram_arbiter;

    localparam int DEPTH = 16;
    localparam logic [1:0] NO = 2'b00, RD = 2'b01, WR = 2'b10, RW = 2'b11;
    localparam logic [1:0] GN = 2'b00, G0 = 2'b01, G1 = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] s0_address, s1_address;
    logic        s0_read, s0_write, s1_read, s1_write;
    logic [3:0]  s0_byteenable, s1_byteenable;
    logic [31:0] s0_writedata, s1_writedata;
    logic        s0_waitrequest, s1_waitrequest;
    logic [31:0] s0_readdata, s1_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic [12:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;
    logic        clear_done, oor_err;

    always #5 clk = ~clk;

    niosii_ram_arbiter #(
        .ADDR_W(13), .DATA_W(32), .BE_W(4), .RAM_DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata), .clear_done(clear_done), .oor_err(oor_err)
    );

    // Single-port RAM with one cycle read latency
    logic [31:0] ram_mem [0:8191];
    always @(posedge clk) begin
        if (ram_clken) begin
            if (ram_chipselect && ram_write)
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            ram_readdata <= ram_mem[ram_address];
        end
    end

    int n_run = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op0, input logic [12:0] a0, input logic [3:0] be0,
                         input logic [31:0] d0, input logic [1:0] op1, input logic [12:0] a1,
                         input logic [3:0] be1, input logic [31:0] d1);
        s0_read = op0[0]; s0_write = op0[1]; s0_address = a0; s0_byteenable = be0; s0_writedata = d0;
        s1_read = op1[0]; s1_write = op1[1]; s1_address = a1; s1_byteenable = be1; s1_writedata = d1;
    endtask

    typedef struct {
        logic [1:0]  op0;  logic [12:0] a0; logic [3:0] be0; logic [31:0] d0;
        logic [1:0]  op1;  logic [12:0] a1; logic [3:0] be1; logic [31:0] d1;
        logic [1:0]  g;    logic cs; logic we; logic [12:0] addr;
        logic [1:0]  v;    logic [31:0] q0; logic [31:0] q1;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op0, input logic [12:0] a0, input logic [3:0] be0,
                                input logic [31:0] d0, input logic [1:0] op1, input logic [12:0] a1,
                                input logic [3:0] be1, input logic [31:0] d1, input logic [1:0] g,
                                input logic cs, input logic we, input logic [12:0] addr,
                                input logic [1:0] v, input logic [31:0] q0, input logic [31:0] q1);
        vec_t r;
        r.op0 = op0; r.a0 = a0; r.be0 = be0; r.d0 = d0;
        r.op1 = op1; r.a1 = a1; r.be1 = be1; r.d1 = d1;
        r.g = g; r.cs = cs; r.we = we; r.addr = addr; r.v = v; r.q0 = q0; r.q1 = q1;
        return r;
    endfunction

    vec_t tbl [15];

    // Behavioural model state for the random phase
    logic [31:0] mem_ref [DEPTH];
    logic [1:0]  p_op [2];
    logic [12:0] p_a  [2];
    logic [3:0]  p_be [2];
    logic [31:0] p_d  [2];
    logic [1:0]  exp_v;
    logic [31:0] exp_q [2];
    logic        m_oor;
    int          last_win;

    initial begin
        for (int i = 0; i < 8192; i++) ram_mem[i] = 32'hDEAD_0000 | i;

        // ---- reset values and clear sweep, s0 write held throughout ----
        reset = 1'b1;
        drive(WR, 13'd2, 4'hF, 32'h1111_2222, NO, 13'd0, 4'h0, 32'h0);
        #12;
        chk1("rst_wait0", s0_waitrequest, 1'b1);
        chk1("rst_wait1", s1_waitrequest, 1'b1);
        chk1("rst_rdv0", s0_readdatavalid, 1'b0);
        chk1("rst_rdv1", s1_readdatavalid, 1'b0);
        chk32("rst_rd0", s0_readdata, 32'h0);
        chk32("rst_rd1", s1_readdata, 32'h0);
        chk1("rst_cs", ram_chipselect, 1'b0);
        chk1("rst_we", ram_write, 1'b0);
        chk32("rst_addr", 32'(ram_address), 32'h0);
        chk1("rst_oor", oor_err, 1'b0);
        chk1("rst_clear_done", clear_done, 1'b0);
        chk1("rst_clken", ram_clken, 1'b1);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk32("clr_addr", 32'(ram_address), i);
            chk1("clr_cs", ram_chipselect, 1'b1);
            chk1("clr_we", ram_write, 1'b1);
            chk32("clr_be", 32'(ram_byteenable), 32'hF);
            chk32("clr_wd", ram_writedata, 32'h0);
            chk1("clr_wait0", s0_waitrequest, 1'b1);
            chk1("clr_done_low", clear_done, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        chk1("clr_done_high", clear_done, 1'b1);
        chk1("clr_held_grant", s0_waitrequest, 1'b0);
        for (int i = 0; i < DEPTH; i++) chk32("clr_mem", ram_mem[i], 32'h0);
        chk32("clr_mem_beyond", ram_mem[DEPTH], 32'hDEAD_0000 | DEPTH);

        // ---- directed cycles (last grant is s0 here) ----
        tbl[0]  = mk(NO, 0, 0, 0,              WR, 5, 4'hF, 32'hCAFE_BEEF, G1, 1, 1, 5, 2'b00, 0, 0);
        tbl[1]  = mk(WR, 5, 4'h3, 32'hA5A5_1234, NO, 0, 0, 0,            G0, 1, 1, 5, 2'b00, 0, 0);
        tbl[2]  = mk(RD, 5, 0, 0,              NO, 0, 0, 0,              G0, 1, 0, 5, 2'b00, 0, 0);
        tbl[3]  = mk(NO, 0, 0, 0,              NO, 0, 0, 0,              GN, 0, 0, 0, 2'b01, 32'hCAFE_1234, 0);
        tbl[4]  = mk(RD, 5, 0, 0,              RD, 2, 0, 0,              G1, 1, 0, 2, 2'b00, 0, 0);
        tbl[5]  = mk(RD, 5, 0, 0,              RD, 2, 0, 0,              G0, 1, 0, 5, 2'b10, 0, 32'h1111_2222);
        tbl[6]  = mk(RD, 5, 0, 0,              RD, 2, 0, 0,              G1, 1, 0, 2, 2'b01, 32'hCAFE_1234, 0);
        tbl[7]  = mk(RD, 5, 0, 0,              RD, 2, 0, 0,              G0, 1, 0, 5, 2'b10, 0, 32'h1111_2222);
        tbl[8]  = mk(RD, 5, 0, 0,              RD, 2, 0, 0,              G1, 1, 0, 2, 2'b01, 32'hCAFE_1234, 0);
        tbl[9]  = mk(RD, 5, 0, 0,              RD, 2, 0, 0,              G0, 1, 0, 5, 2'b10, 0, 32'h1111_2222);
        tbl[10] = mk(NO, 0, 0, 0,              NO, 0, 0, 0,              GN, 0, 0, 0, 2'b01, 32'hCAFE_1234, 0);
        tbl[11] = mk(RW, 3, 4'hF, 32'h0000_0055, NO, 0, 0, 0,            G0, 1, 1, 3, 2'b00, 0, 0);
        tbl[12] = mk(NO, 0, 0, 0,              NO, 0, 0, 0,              GN, 0, 0, 0, 2'b00, 0, 0);
        tbl[13] = mk(NO, 0, 0, 0,              RD, 3, 0, 0,              G1, 1, 0, 3, 2'b00, 0, 0);
        tbl[14] = mk(NO, 0, 0, 0,              NO, 0, 0, 0,              GN, 0, 0, 0, 2'b10, 0, 32'h0000_0055);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].op0, tbl[i].a0, tbl[i].be0, tbl[i].d0, tbl[i].op1, tbl[i].a1, tbl[i].be1, tbl[i].d1);
            @(negedge clk);
            chk1("tbl_wait0", s0_waitrequest, ~tbl[i].g[0]);
            chk1("tbl_wait1", s1_waitrequest, ~tbl[i].g[1]);
            chk1("tbl_cs", ram_chipselect, tbl[i].cs);
            chk1("tbl_we", ram_write, tbl[i].we);
            if (tbl[i].g != GN) chk32("tbl_addr", 32'(ram_address), 32'(tbl[i].addr));
            chk1("tbl_rdv0", s0_readdatavalid, tbl[i].v[0]);
            chk1("tbl_rdv1", s1_readdatavalid, tbl[i].v[1]);
            chk32("tbl_rd0", s0_readdata, tbl[i].q0);
            chk32("tbl_rd1", s1_readdata, tbl[i].q1);
        end

        // ---- randomized traffic against the behavioural model ----
        for (int i = 0; i < DEPTH; i++) mem_ref[i] = 32'h0;
        mem_ref[2] = 32'h1111_2222;
        mem_ref[3] = 32'h0000_0055;
        mem_ref[5] = 32'hCAFE_1234;
        last_win = 1;
        m_oor = 1'b0;
        exp_v = 2'b00;
        for (int p = 0; p < 2; p++) p_op[p] = NO;
        for (int c = 0; c < 400; c++) begin
            int  win;
            logic inr;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (p_op[p] == NO && $urandom_range(0, 9) < 6) begin
                    p_op[p] = 2'($urandom_range(1, 3));
                    p_a[p]  = 13'($urandom_range(0, DEPTH + 3));
                    p_be[p] = 4'($urandom_range(0, 15));
                    p_d[p]  = $urandom;
                end
            end
            drive(p_op[0], p_a[0], p_be[0], p_d[0], p_op[1], p_a[1], p_be[1], p_d[1]);
            @(negedge clk);
            if (p_op[0] != NO && p_op[1] != NO) win = (last_win == 1) ? 0 : 1;
            else if (p_op[0] != NO)             win = 0;
            else if (p_op[1] != NO)             win = 1;
            else                                win = -1;
            inr = (win >= 0) && (p_a[win] < DEPTH);
            chk1("rnd_wait0", s0_waitrequest, win != 0);
            chk1("rnd_wait1", s1_waitrequest, win != 1);
            chk1("rnd_cs", ram_chipselect, inr);
            chk1("rnd_rdv0", s0_readdatavalid, exp_v[0]);
            chk1("rnd_rdv1", s1_readdatavalid, exp_v[1]);
            chk32("rnd_rd0", s0_readdata, exp_v[0] ? exp_q[0] : 32'h0);
            chk32("rnd_rd1", s1_readdata, exp_v[1] ? exp_q[1] : 32'h0);
            chk1("rnd_oor", oor_err, m_oor);
            exp_v = 2'b00;
            if (win >= 0) begin
                if (p_op[win][1]) begin
                    if (inr)
                        for (int b = 0; b < 4; b++)
                            if (p_be[win][b]) mem_ref[p_a[win][3:0]][8*b +: 8] = p_d[win][8*b +: 8];
                end else begin
                    exp_v[win] = 1'b1;
                    exp_q[win] = inr ? mem_ref[p_a[win][3:0]] : 32'h0;
                end
                if (!inr) m_oor = 1'b1;
                last_win = win;
                p_op[win] = NO;
            end
        end

        // ---- reset on the cycle after a read is accepted ----
        @(posedge clk); #1;
        drive(RD, 13'd5, 4'h0, 32'h0, NO, 13'd0, 4'h0, 32'h0);
        @(negedge clk);
        chk1("rmr_grant", s0_waitrequest, 1'b0);
        @(posedge clk); #1;
        drive(NO, 13'd0, 4'h0, 32'h0, RD, 13'd0, 4'h0, 32'h0);
        reset = 1'b1;
        #1;
        chk1("rmr_rdv0", s0_readdatavalid, 1'b0);
        chk32("rmr_rd0", s0_readdata, 32'h0);
        chk1("rmr_wait0", s0_waitrequest, 1'b1);
        chk1("rmr_wait1", s1_waitrequest, 1'b1);
        chk1("rmr_cs", ram_chipselect, 1'b0);
        chk1("rmr_we", ram_write, 1'b0);
        chk32("rmr_addr", 32'(ram_address), 32'h0);
        chk1("rmr_oor", oor_err, 1'b0);
        chk1("rmr_clear_done", clear_done, 1'b0);
        @(posedge clk); #1;
        chk1("rmr_rdv0_held", s0_readdatavalid, 1'b0);
        reset = 1'b0;

        // ---- reset in the middle of the clear sweep ----
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk1("rmc_cs", ram_chipselect, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk32("rmc_addr", 32'(ram_address), i);
            chk1("rmc_we", ram_write, 1'b1);
            chk1("rmc_wait1", s1_waitrequest, 1'b1);
            chk1("rmc_done_low", clear_done, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        chk1("rmc_done_high", clear_done, 1'b1);
        chk1("rmc_grant1", s1_waitrequest, 1'b0);
        chk1("rmc_rd_cs", ram_chipselect, 1'b1);

        // ---- out-of-range accesses and the in-range boundary ----
        @(posedge clk); #1;
        drive(NO, 13'd0, 4'h0, 32'h0, WR, 13'd6400, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        chk1("oor_rdv1_cleared", s1_readdatavalid, 1'b1);
        chk32("oor_rd1_cleared", s1_readdata, 32'h0);
        chk1("oor_wr_grant", s1_waitrequest, 1'b0);
        chk1("oor_wr_cs", ram_chipselect, 1'b0);
        chk1("oor_wr_we", ram_write, 1'b0);
        chk1("oor_flag_before", oor_err, 1'b0);
        @(posedge clk); #1;
        drive(NO, 13'd0, 4'h0, 32'h0, RD, 13'd6400, 4'h0, 32'h0);
        @(negedge clk);
        chk1("oor_rd_grant", s1_waitrequest, 1'b0);
        chk1("oor_rd_cs", ram_chipselect, 1'b0);
        chk1("oor_flag_set", oor_err, 1'b1);
        chk1("oor_wr_no_rdv", s1_readdatavalid, 1'b0);
        @(posedge clk); #1;
        drive(RD, 13'd15, 4'h0, 32'h0, NO, 13'd0, 4'h0, 32'h0);
        @(negedge clk);
        chk1("oor_rdv1", s1_readdatavalid, 1'b1);
        chk32("oor_rd1_zero", s1_readdata, 32'h0);
        chk1("edge15_cs", ram_chipselect, 1'b1);
        chk32("edge15_addr", 32'(ram_address), 32'd15);
        @(posedge clk); #1;
        drive(RD, 13'd16, 4'h0, 32'h0, NO, 13'd0, 4'h0, 32'h0);
        @(negedge clk);
        chk1("edge15_rdv0", s0_readdatavalid, 1'b1);
        chk1("edge16_cs", ram_chipselect, 1'b0);
        chk1("edge16_grant", s0_waitrequest, 1'b0);
        @(posedge clk); #1;
        drive(NO, 13'd0, 4'h0, 32'h0, NO, 13'd0, 4'h0, 32'h0);
        @(negedge clk);
        chk1("edge16_rdv0", s0_readdatavalid, 1'b1);
        chk32("edge16_rd0_zero", s0_readdata, 32'h0);
        chk32("oor_mem_kept", ram_mem[6400], 32'hDEAD_0000 | 6400);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("oor_sticky", oor_err, 1'b1);
        reset = 1'b1;
        #1 chk1("oor_reset", oor_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
